// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg
// Shared definitions for the Ethernet TX framer: FSM state encoding, line
// constants (preamble/SFD), CRC-32 constants and the byte-wide reflected
// CRC-32 update used by eth_crc32_d8.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY_REFL   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB20E3;

    localparam int          CNT_W             = 11;

    // One byte of LSB-first CRC-32, eight serial steps unrolled.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8
// Byte-wide CRC-32 register (no final XOR applied on the output).
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, loads CRC32_INIT
//   init  - synchronous re-seed to CRC32_INIT (wins over en)
//   en    - fold data into the running CRC this cycle
//   data  - byte to fold in
//   crc   - running CRC register value
module eth_crc32_d8
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_next(crc, data);
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer
// Wraps a MAC payload stream into a GMII frame: preamble, SFD, data,
// zero padding up to MIN_FRAME, 4-byte FCS, then an inter-frame gap.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   mac_data_i        - payload byte from the TX mux
//   mac_valid_i       - held high for the whole frame; low ends the frame
//   mac_ack_o         - payload byte consumed this cycle (combinational)
//   gmii_txd_o        - registered line byte
//   gmii_tx_en_o      - registered line byte valid
//   busy_o            - framer is not idle
//   frame_done_o      - one-cycle strobe alongside the last FCS byte
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for mac_valid_i; first preamble byte loaded on exit
// ST_PREAMBLE | loading the remaining PREAMBLE_LEN-1 preamble bytes
// ST_SFD      | loading the start-of-frame delimiter
// ST_DATA     | acking payload bytes; on valid low loads first pad/FCS byte
// ST_PAD      | loading zero pad until MIN_FRAME, then the first FCS byte
// ST_FCS      | loading FCS bytes 1..3, strobe done with the last one
// ST_IFG      | line idle for IFG_BYTES cycles
//
// The state names the byte being loaded into the line register, so each
// line byte appears one cycle after the state that produced it. The two
// boundary states (IDLE, DATA) also load the first byte of the following
// state so that the line never bubbles.
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mac_data_i,
    input  logic       mac_valid_i,
    output logic       mac_ack_o,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    tx_state_t          state;
    tx_state_t          state_next;

    logic [CNT_W-1:0]   byte_cnt;
    logic [7:0]         tmr;
    logic [1:0]         fcs_idx;
    logic [31:0]        crc;
    logic [31:0]        fcs_word;
    logic [7:0]         fcs_byte;
    logic               pad_needed;

    logic               data_ack_tx;
    logic               emit_en;
    logic [7:0]         emit_byte;
    logic               crc_en;
    logic               fcs_emit;
    logic               done_next;

    assign fcs_word   = ~crc;
    assign pad_needed = byte_cnt < CNT_W'(MIN_FRAME);

    always_comb begin
        unique case (fcs_idx)
            2'd0:    fcs_byte = fcs_word[7:0];
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (mac_valid_i) begin
                    state_next = (PREAMBLE_LEN > 1) ? ST_PREAMBLE : ST_SFD;
                end
            end
            ST_PREAMBLE: begin
                if (tmr == 8'd1) begin
                    state_next = ST_SFD;
                end
            end
            ST_SFD: begin
                state_next = ST_DATA;
            end
            ST_DATA: begin
                if (!mac_valid_i) begin
                    state_next = pad_needed ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                if (!pad_needed) begin
                    state_next = ST_FCS;
                end
            end
            ST_FCS: begin
                if (fcs_idx == 2'd3) begin
                    state_next = ST_IFG;
                end
            end
            ST_IFG: begin
                if (tmr == 8'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode: what gets loaded into the line register this cycle
    always_comb begin
        data_ack_tx = 1'b0;
        emit_en     = 1'b0;
        emit_byte   = 8'h00;
        crc_en      = 1'b0;
        fcs_emit    = 1'b0;
        done_next   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mac_valid_i) begin
                    emit_en   = 1'b1;
                    emit_byte = ETH_PREAMBLE_BYTE;
                end
            end
            ST_PREAMBLE: begin
                emit_en   = 1'b1;
                emit_byte = ETH_PREAMBLE_BYTE;
            end
            ST_SFD: begin
                emit_en   = 1'b1;
                emit_byte = ETH_SFD_BYTE;
            end
            ST_DATA, ST_PAD: begin
                emit_en = 1'b1;
                if (state == ST_DATA && mac_valid_i) begin
                    data_ack_tx = 1'b1;
                    emit_byte   = mac_data_i;
                    crc_en      = 1'b1;
                end else if (pad_needed) begin
                    emit_byte = 8'h00;
                    crc_en    = 1'b1;
                end else begin
                    emit_byte = fcs_byte;
                    fcs_emit  = 1'b1;
                end
            end
            ST_FCS: begin
                emit_en   = 1'b1;
                emit_byte = fcs_byte;
                fcs_emit  = 1'b1;
                done_next = (fcs_idx == 2'd3);
            end
            default: ;
        endcase
    end

    assign mac_ack_o = data_ack_tx;
    assign busy_o    = (state != ST_IDLE);

    // Counters and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt     <= '0;
            tmr          <= 8'd0;
            fcs_idx      <= 2'd0;
            gmii_txd_o   <= 8'h00;
            gmii_tx_en_o <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            gmii_txd_o   <= emit_byte;
            gmii_tx_en_o <= emit_en;
            frame_done_o <= done_next;

            // Saturates so very long frames are never mistaken for short ones.
            if (state == ST_IDLE) begin
                byte_cnt <= '0;
            end else if (crc_en && byte_cnt != {CNT_W{1'b1}}) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            // Wraps back to 0 after the fourth FCS byte.
            if (state == ST_IDLE) begin
                fcs_idx <= 2'd0;
            end else if (fcs_emit) begin
                fcs_idx <= fcs_idx + 2'd1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (mac_valid_i) begin
                        tmr <= 8'(PREAMBLE_LEN - 1);
                    end
                end
                ST_PREAMBLE: begin
                    tmr <= tmr - 8'd1;
                end
                ST_FCS: begin
                    if (fcs_idx == 2'd3) begin
                        tmr <= 8'(IFG_BYTES - 1);
                    end
                end
                ST_IFG: begin
                    if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    eth_crc32_d8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (state == ST_IDLE),
        .en   (crc_en),
        .data (emit_byte),
        .crc  (crc)
    );

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer
// Scoreboard bench: each frame sent pushes its expected line bytes into a
// queue; a negedge monitor pops and compares whatever the DUT puts on the line.
module tb_eth_tx_framer;

    localparam int MIN_FRAME = 60;
    localparam int IFG_BYTES = 12;
    localparam int PRE_LEN   = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mac_data;
    logic       mac_valid;
    logic       mac_ack;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       busy;
    logic       frame_done;

    logic        tcrc_init;
    logic        tcrc_en;
    logic [7:0]  tcrc_data;
    logic [31:0] tcrc;

    always #5 clk = ~clk;

    eth_tx_framer #(
        .MIN_FRAME    (MIN_FRAME),
        .IFG_BYTES    (IFG_BYTES),
        .PREAMBLE_LEN (PRE_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mac_data_i   (mac_data),
        .mac_valid_i  (mac_valid),
        .mac_ack_o    (mac_ack),
        .gmii_txd_o   (gmii_txd),
        .gmii_tx_en_o (gmii_tx_en),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    eth_crc32_d8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (tcrc_init),
        .en   (tcrc_en),
        .data (tcrc_data),
        .crc  (tcrc)
    );

    typedef struct {
        logic [7:0] b;
        bit         first;
        bit         last;
        bit         body;
        bit         b2b;
        int         n;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pl[$];

    int          checks = 0;
    int          errors = 0;

    // Driver-to-monitor check requests; only the monitor touches the counts.
    int          chk_req = 0;
    int          chk_seen = 0;
    int          chk_kind = 0;
    logic [31:0] chk_exp32 = 32'h0;
    string       chk_name = "";
    bit          skip = 1'b0;

    logic [7:0]  vec [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                             8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0]  vec_fcs [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            if ((c[0] ^ d[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else                       c = c >> 1;
        end
        return c;
    endfunction

    function automatic exp_t mk(input logic [7:0] b, input bit first, input bit last,
                                input bit body, input bit b2b, input int n);
        exp_t e;
        e.b = b; e.first = first; e.last = last; e.body = body; e.b2b = b2b; e.n = n;
        return e;
    endfunction

    // Reference frame: preamble, SFD, payload, zero pad to MIN_FRAME, FCS LSB first.
    task automatic push_expected(input bit b2b);
        logic [31:0] c;
        logic [31:0] fcs;
        int          len;
        for (int k = 0; k < PRE_LEN; k++) exp_q.push_back(mk(8'h55, k == 0, 0, 0, b2b, 0));
        exp_q.push_back(mk(8'hD5, 0, 0, 0, b2b, 0));
        c = 32'hFFFFFFFF;
        len = 0;
        foreach (pl[k]) begin
            exp_q.push_back(mk(pl[k], 0, 0, 1, b2b, 0));
            c = ref_crc(c, pl[k]);
            len++;
        end
        while (len < MIN_FRAME) begin
            exp_q.push_back(mk(8'h00, 0, 0, 1, b2b, 0));
            c = ref_crc(c, 8'h00);
            len++;
        end
        fcs = ~c;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(fcs[8*k +: 8], 0, k == 3, 1, b2b, pl.size()));
        end
    endtask

    task automatic req(input int kind, input logic [31:0] e, input string name);
        chk_kind  = kind;
        chk_exp32 = e;
        chk_name  = name;
        chk_req++;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) begin
            req(4, 32'h0, "wait_idle");
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int n, input bit b2b, input int abort_at);
        int   i;
        int   guard;
        logic got;
        bit   gap_chk;
        pl.delete();
        for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
        gap_chk = b2b && (n > 0) && (abort_at < 0);
        if (!gap_chk) wait_idle();
        if (abort_at < 0) push_expected(gap_chk);
        else              skip = 1'b1;
        mac_valid = 1'b1;
        mac_data  = (n > 0) ? pl[0] : 8'h00;
        if (n == 0) begin
            // Valid held through IDLE, preamble and SFD, dropped on the first DATA cycle.
            repeat (PRE_LEN + 1) @(posedge clk);
            #1;
            mac_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        i = 0;
        guard = 0;
        while (i < n) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                req(3, 32'h0, "abort");
                @(posedge clk); #1;
                rst = 1'b0;
                mac_valid = 1'b0;
                mac_data = 8'h00;
                @(posedge clk); #1;
                skip = 1'b0;
                return;
            end
            @(negedge clk);
            got = mac_ack;
            @(posedge clk); #1;
            if (got) begin
                i++;
                if (i < n) mac_data = pl[i];
            end
            guard++;
            if (guard > 4000) begin
                req(4, 32'h0, "ack_wait");
                mac_valid = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        mac_valid = 1'b0;
        mac_data  = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor / scoreboard
    int          cyc = 0;
    int          last_done_cyc = 0;
    int          ack_cnt = 0;
    logic        prev_en = 1'b0;
    logic [31:0] res = 32'hFFFFFFFF;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (chk_req != chk_seen) begin
            chk_seen = chk_req;
            case (chk_kind)
                1: begin
                    chk("reset_txd", {24'h0, gmii_txd}, 32'h0);
                    chk("reset_tx_en", {31'h0, gmii_tx_en}, 32'h0);
                    chk("reset_ack", {31'h0, mac_ack}, 32'h0);
                    chk("reset_busy", {31'h0, busy}, 32'h0);
                    chk("reset_done", {31'h0, frame_done}, 32'h0);
                end
                2: chk("crc_123456789", ~tcrc, chk_exp32);
                3: begin
                    chk("abort_tx_en", {31'h0, gmii_tx_en}, 32'h0);
                    chk("abort_ack", {31'h0, mac_ack}, 32'h0);
                    chk("abort_busy", {31'h0, busy}, 32'h0);
                end
                5: chk("crc_vec_residue", tcrc, chk_exp32);
                default: begin
                    checks++;
                    errors++;
                    $display("FAIL timeout %s", chk_name);
                end
            endcase
        end
        if (skip) begin
            ack_cnt = 0;
        end else begin
            if (mac_valid && mac_ack) ack_cnt++;
            if (gmii_tx_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte got %02h expected none", gmii_txd);
                end else begin
                    e = exp_q.pop_front();
                    chk("line_byte", {24'h0, gmii_txd}, {24'h0, e.b});
                    chk("frame_start", {31'h0, !prev_en}, {31'h0, e.first});
                    chk("frame_done", {31'h0, frame_done}, {31'h0, e.last});
                    if (e.first) begin
                        res = 32'hFFFFFFFF;
                        if (e.b2b) chk("ifg_gap", cyc - last_done_cyc, IFG_BYTES + 1);
                    end
                    if (e.body) res = ref_crc(res, gmii_txd);
                    if (e.last) begin
                        chk("fcs_residue", res, 32'hDEBB20E3);
                        chk("ack_count", ack_cnt, e.n);
                        ack_cnt = 0;
                        last_done_cyc = cyc;
                    end
                end
            end else if (frame_done) begin
                chk("done_without_tx_en", {31'h0, frame_done}, 32'h0);
            end
        end
        prev_en = gmii_tx_en;
    end

    initial begin
        int guard;
        rst       = 1'b1;
        mac_valid = 1'b0;
        mac_data  = 8'h00;
        tcrc_init = 1'b0;
        tcrc_en   = 1'b0;
        tcrc_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        req(1, 32'h0, "reset");
        @(posedge clk); #1;
        rst = 1'b0;

        tcrc_init = 1'b1;
        @(posedge clk); #1;
        tcrc_init = 1'b0;
        tcrc_en   = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tcrc_data = vec[k];
            @(posedge clk); #1;
        end
        tcrc_en = 1'b0;
        req(2, 32'hCBF43926, "crc");
        @(posedge clk); #1;
        tcrc_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tcrc_data = vec_fcs[k];
            @(posedge clk); #1;
        end
        tcrc_en = 1'b0;
        req(5, 32'hDEBB20E3, "residue");
        @(posedge clk); #1;

        send_frame(42, 1'b0, -1);
        send_frame(98, 1'b1, -1);
        send_frame(0, 1'b0, -1);
        send_frame(59, 1'b1, -1);
        send_frame(60, 1'b1, -1);
        send_frame(61, 1'b1, -1);
        send_frame(1, 1'b1, -1);
        for (int r = 0; r < 12; r++) begin
            send_frame(int'($urandom_range(130, 0)), bit'($urandom_range(1, 0)), -1);
        end
        send_frame(2060, 1'b1, -1);
        send_frame(40, 1'b0, 19);
        send_frame(50, 1'b0, -1);

        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0 || busy) begin
            req(4, 32'h0, "drain");
        end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum bytes before FCS; shorter frames zero-padded.
REQ-002 SHALL have parameter IFG_BYTES, default 12, idle byte-times after each FCS.
REQ-003 SHALL have parameter PREAMBLE_LEN, default 7, count of 0x55 bytes before SFD.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mac_data_i  in  8  payload byte from TX mux (dst MAC first).
REQ-007 mac_valid_i  in  1  upstream holds high for whole frame; low after last byte ends frame.
REQ-008 mac_ack_o  out  1  byte consumed this cycle; upstream advances on valid&&ack.
REQ-009 gmii_txd_o  out  8  line byte.
REQ-010 gmii_tx_en_o  out  1  line byte valid; no backpressure, one byte per cycle.
REQ-011 busy_o  out  1  high in any state other than IDLE.
REQ-012 frame_done_o  out  1  one-cycle strobe with last FCS byte.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-014 IDLE->PREAMBLE on mac_valid_i=1; first 0x55 on gmii_txd_o the following cycle.
REQ-015 PREAMBLE emits PREAMBLE_LEN bytes 0x55, then SFD emits one byte 0xD5.
REQ-016 mac_ack_o SHALL equal mac_valid_i in DATA only, 0 elsewhere (combinational); each acked byte registered to gmii_txd_o next cycle.
REQ-017 DATA with mac_valid_i=0: ->PAD if byte count < MIN_FRAME, else ->FCS; no bubble on tx_en.
REQ-018 PAD emits 0x00 until byte count = MIN_FRAME, then ->FCS.
REQ-019 CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, over data and pad bytes only, final XOR 0xFFFFFFFF.
REQ-020 FCS emits 4 bytes, CRC bits [7:0] first through [31:24]; frame_done_o with 4th byte; ->IFG.
REQ-021 IFG holds tx_en=0 for IFG_BYTES cycles, then ->IDLE; mac_valid_i during IFG not acked until IDLE.
REQ-022 Byte counter 11-bit, saturating at 2047; no truncation of long frames.
REQ-023 Zero-length frame (valid dropped on first DATA cycle) SHALL emit MIN_FRAME pad bytes plus FCS.
REQ-024 gmii_tx_en_o SHALL be 1 exactly in PREAMBLE, SFD, DATA (registered), PAD, FCS output cycles, contiguous.

Reset
REQ-025 rst SHALL force IDLE, CRC=0xFFFFFFFF, counters=0, gmii_txd_o=0x00, gmii_tx_en_o=0, mac_ack_o=0, busy_o=0, frame_done_o=0 on next edge.
REQ-026 rst mid-frame SHALL drop tx_en the next cycle with no FCS emitted; upstream frame remainder is not acked.

Structure
REQ-027 Package eth_tx_pkg SHALL hold the state enum, ETH_PREAMBLE_BYTE=0x55, ETH_SFD_BYTE=0xD5, CRC32_POLY_REFL, CRC32_INIT, CRC32_RESIDUE=0xDEBB20E3.
REQ-028 Byte-wide CRC update SHALL be sub-module eth_crc32_d8 (clk, rst, init, en, data[7:0], crc[31:0]), purely datapath.
REQ-029 Instantiated in the top between the TX mux and the MAC pins, DATA_ACK_TX driven by mac_ack_o.

Verification
REQ-030 eth_crc32_d8 fed ASCII "123456789" -> final-XOR CRC 0xCBF43926, FCS bytes 26 39 F4 CB.
REQ-031 42-byte ARP reply -> 7x0x55, 0xD5, 42 data, 18x0x00, 4 FCS: 72 contiguous tx_en cycles, frame_done_o at cycle 72, then 12 idle cycles.
REQ-032 Any emitted frame: CRC register (no final XOR) over data+pad+FCS equals 0xDEBB20E3.
REQ-033 98-byte ICMP reply -> no pad, 8+98+4=110 tx_en cycles, 98 mac_ack_o pulses.
REQ-034 Back-to-back: second frame valid during IFG -> first preamble byte exactly 13 cycles after first frame's last FCS byte.
REQ-035 rst asserted on 20th data byte -> tx_en low next cycle, ack low, busy_o low; next frame transmits normally with correct FCS.
